// File: rtl/seg_display_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : seg_display_bank                                                |
// | Function : Bank of DIGITS hex 7-segment drivers with per-digit blink,      |
// |            global blank and optional leading-zero blanking, which is       |
// |            enabled by defining SEG_DISPLAY_BANK_LZB_EN.                    |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module seg_display_bank #(
    parameter int DIGITS    = 4,
    parameter int BLINK_DIV = 25000000
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     blink_mask,
    input  logic                  blank_all,
    output logic [7*DIGITS-1:0]   hex,
    output logic                  load_ack
);

    localparam int               CNT_W   = $clog2(BLINK_DIV);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BLINK_DIV - 1);

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_e;

    state_e                state_q;
    logic [4*DIGITS-1:0]   digits_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  phase_q;
    logic                  load_ack_q;
    logic                  blank_q;
    logic [DIGITS-1:0]     mask_q;
    logic [7*DIGITS-1:0]   hex_q;
    logic [7*DIGITS-1:0]   hex_d;
    logic [3:0]            nib;
    logic [6:0]            seg;
`ifdef SEG_DISPLAY_BANK_LZB_EN
    logic                  lead_zero;
`endif

    function automatic logic [6:0] glyph(input logic [3:0] d);
        case (d)
            4'h0:    glyph = 7'b1000000;
            4'h1:    glyph = 7'b1111001;
            4'h2:    glyph = 7'b0100100;
            4'h3:    glyph = 7'b0110000;
            4'h4:    glyph = 7'b0011001;
            4'h5:    glyph = 7'b0010010;
            4'h6:    glyph = 7'b0000010;
            4'h7:    glyph = 7'b1111000;
            4'h8:    glyph = 7'b0000000;
            4'h9:    glyph = 7'b0010000;
            4'hA:    glyph = 7'b0001000;
            4'hB:    glyph = 7'b0000011;
            4'hC:    glyph = 7'b1000110;
            4'hD:    glyph = 7'b0100001;
            4'hE:    glyph = 7'b0000110;
            default: glyph = 7'b0001110;
        endcase
    endfunction

    // Inputs are sampled into registers first, so every input reaches hex one edge later.
    always_comb begin
        hex_d = '1;
        nib   = '0;
        seg   = '1;
`ifdef SEG_DISPLAY_BANK_LZB_EN
        lead_zero = 1'b1;
`endif
        for (int i = DIGITS - 1; i >= 0; i--) begin
            nib = digits_q[4*i +: 4];
            seg = glyph(nib);
`ifdef SEG_DISPLAY_BANK_LZB_EN
            if (lead_zero && (nib == 4'd0) && (i != 0)) begin
                seg = '1;
            end
            if (nib != 4'd0) begin
                lead_zero = 1'b0;
            end
`endif
            if (mask_q[i] && phase_q) begin
                seg = '1;
            end
            hex_d[7*i +: 7] = seg;
        end
        if ((state_q == ST_BLANK) || blank_q) begin
            hex_d = '1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_BLANK;
            digits_q   <= '0;
            cnt_q      <= '0;
            phase_q    <= 1'b0;
            load_ack_q <= 1'b0;
            blank_q    <= 1'b0;
            mask_q     <= '0;
            hex_q      <= '1;
        end else begin
            if (load) begin
                state_q  <= ST_SHOW;
                digits_q <= value;
            end
            load_ack_q <= load;
            if (cnt_q == CNT_MAX) begin
                cnt_q   <= '0;
                phase_q <= ~phase_q;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
            blank_q <= blank_all;
            mask_q  <= blink_mask;
            hex_q   <= hex_d;
        end
    end

    assign hex      = hex_q;
    assign load_ack = load_ack_q;

endmodule
`default_nettype wire

// File: tb/tb_seg_display_bank.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_seg_display_bank                                             |
// | Function : Randomized scoreboard bench for seg_display_bank (DIGITS=4,     |
// |            BLINK_DIV=4); honours SEG_DISPLAY_BANK_LZB_EN.                  |
// | Revision : 1.0                                                             |
// +----------------------------------------------------------------------------+
module tb_seg_display_bank;

    localparam int DIGITS    = 4;
    localparam int BLINK_DIV = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        load = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  blink_mask = '0;
    logic        blank_all = 1'b0;
    logic [27:0] hex;
    logic        load_ack;

    seg_display_bank #(.DIGITS(DIGITS), .BLINK_DIV(BLINK_DIV)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .value      (value),
        .blink_mask (blink_mask),
        .blank_all  (blank_all),
        .hex        (hex),
        .load_ack   (load_ack)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [27:0] hex;
        logic        ack;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_mon   = 0;

    logic [6:0] GLYPH [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Reference state: what the display has captured and how long since reset.
    bit          m_cap   = 1'b0;
    logic [15:0] m_val   = '0;
    int unsigned m_edges = 0;
    bit          m_blank = 1'b0;
    logic [3:0]  m_mask  = '0;
`ifdef SEG_DISPLAY_BANK_LZB_EN
    bit          lzb_on  = 1'b1;
`else
    bit          lzb_on  = 1'b0;
`endif

    function automatic logic [27:0] model_hex();
        logic [27:0] h;
        bit          phase;
        h = '1;
        if (!m_cap || m_blank) return h;
        phase = ((m_edges / BLINK_DIV) % 2) == 1;
        for (int i = 0; i < DIGITS; i++) begin
            logic [6:0] g;
            g = GLYPH[m_val[4*i +: 4]];
            if (lzb_on && i > 0 && ((m_val >> (4*i)) == 16'd0)) g = '1;
            if (m_mask[i] && phase) g = '1;
            h[7*i +: 7] = g;
        end
        return h;
    endfunction

    task automatic step(input bit r, input bit ld, input logic [15:0] v,
                        input logic [3:0] m, input bit b);
        exp_t e;
        rst_n = ~r; load = ld; value = v; blink_mask = m; blank_all = b;
        @(posedge clk);
        #1;
        if (r) begin
            e.hex = '1; e.ack = 1'b0;
            m_cap = 1'b0; m_val = '0; m_edges = 0; m_blank = 1'b0; m_mask = '0;
        end else begin
            e.hex = model_hex();
            e.ack = ld;
            if (ld) begin
                m_cap = 1'b1;
                m_val = v;
            end
            m_edges++;
            m_blank = b;
            m_mask  = m;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            n_mon++;
            n_tests++;
            if (hex !== e.hex) begin
                n_fail++;
                $display("FAIL hex check %0d: got %b expected %b", n_mon, hex, e.hex);
            end
            n_tests++;
            if (load_ack !== e.ack) begin
                n_fail++;
                $display("FAIL load_ack check %0d: got %b expected %b", n_mon, load_ack, e.ack);
            end
        end
    end

    initial begin
        logic [15:0] rv;
        step(1, 0, 16'h0000, 4'h0, 0);
        step(1, 0, 16'h0000, 4'h0, 0);
        repeat (5) step(0, 0, 16'h0000, 4'h0, 0);
        step(0, 1, 16'h12AF, 4'h0, 0);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
        repeat (14) step(0, 0, 16'h0000, 4'b0001, 0);
        step(0, 1, 16'h0070, 4'h0, 0);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
        step(0, 0, 16'h0000, 4'h0, 1);
        step(0, 1, 16'h8888, 4'h0, 1);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 1);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
        repeat (3) step(0, 1, 16'h3C0D, 4'h0, 0);
        step(1, 1, 16'h5555, 4'h0, 0);
        repeat (6) step(0, 0, 16'h5555, 4'hF, 0);
        step(0, 1, 16'h0001, 4'h0, 0);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
        step(0, 1, 16'h0000, 4'h0, 0);
        repeat (3) step(0, 0, 16'h0000, 4'h0, 0);
        for (int k = 0; k < 400; k++) begin
            rv = 16'($urandom);
            case ($urandom_range(0, 3))
                0: rv = rv & 16'h000F;
                1: rv = rv & 16'h00FF;
                2: rv = rv & 16'h0FF0;
                default: ;
            endcase
            step($urandom_range(0, 49) == 0, $urandom_range(0, 3) == 0, rv,
                 4'($urandom), $urandom_range(0, 9) == 0);
        end
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) @(negedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/seg_display_bank.md
SEG_DISPLAY_BANK -- requirements
Module: seg_display_bank

Interface
REQ-001 SHALL have parameter DIGITS, default 4, number of hex digits driven (1..8).
REQ-002 SHALL have parameter BLINK_DIV, default 25000000, clock cycles per blink half-period (>=2).
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port load  input  1  when high, value is captured at the next clk edge.
REQ-006 SHALL have port value  input  4*DIGITS  digit i occupies bits [4i+3:4i]; digit 0 is least significant.
REQ-007 SHALL have port blink_mask  input  DIGITS  bit i high makes digit i blink.
REQ-008 SHALL have port blank_all  input  1  when high, all segments are forced off.
REQ-009 SHALL have port hex  output  7*DIGITS  digit i segments at [7i+6:7i], order gfedcba, active-low (0 = lit).
REQ-010 SHALL have port load_ack  output  1  one-cycle pulse confirming a capture.

Function
REQ-011 SHALL provide two states: BLANK (nothing captured since reset) and SHOW.
REQ-012 SHALL transition BLANK->SHOW on the first edge with load=1; there is no SHOW->BLANK transition except via reset.
REQ-013 SHALL latch value into an internal digit register on every edge with load=1, in either state.
REQ-014 SHALL assert load_ack for exactly the cycle after each edge with load=1; load held high for N cycles gives N ack pulses.
REQ-015 SHALL register hex, so an input change sampled at edge k is visible on hex after edge k+1, giving one cycle of latency.
REQ-016 SHALL decode each digit to the standard active-low hex glyph: 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
REQ-017 SHALL keep a blink counter that runs 0..BLINK_DIV-1 and wraps, toggling a phase bit at each wrap; the counter free-runs and is unaffected by load.
REQ-018 SHALL drive digit i to 1111111 when phase=1 and blink_mask[i]=1.
REQ-019 SHALL drive all digits to 1111111 while in the BLANK state or while blank_all=1.
REQ-020 SHALL apply these priorities: blank_all / BLANK state > blink > leading-zero blanking > glyph.
REQ-021 SHALL let a load and a blink wrap on the same edge both take effect.

Reset
REQ-022 SHALL on an edge with rst_n=0 set state=BLANK, the digit register to 0, the blink counter to 0, phase to 0, load_ack to 0, and every bit of hex to 1.
REQ-023 SHALL give rst_n priority over load, and drop any capture in progress.
REQ-024 SHALL make hex all 1s on the edge where reset is applied; the first load after release behaves as in REQ-012.

Configuration
REQ-025 SHALL compile leading-zero blanking in only when macro SEG_DISPLAY_BANK_LZB_EN is defined.
REQ-026 With SEG_DISPLAY_BANK_LZB_EN defined, SHALL blank every zero digit above the most significant nonzero digit; digit 0 is never blanked by this rule.
REQ-027 Without SEG_DISPLAY_BANK_LZB_EN, SHALL display every digit, including leading zeros.

Verification (DIGITS=4, BLINK_DIV=4)
REQ-028 Apply reset, then idle 5 cycles -> hex=all 1s and load_ack=0 throughout.
REQ-029 Pulse load with value=16'h12AF -> one cycle after the load edge: hex[27:21]=1111001, hex[20:14]=0100100, hex[13:7]=0001000, hex[6:0]=0001110, plus a single load_ack pulse.
REQ-030 Set blink_mask=4'b0001 after the load -> digit 0 alternates glyph/1111111 every 4 cycles; digits 1-3 stay steady.
REQ-031 Load value=16'h0070 -> without the macro, digit 3 shows 1000000; with the macro, digits 3 and 2 show 1111111 and digit 1 shows 1111000.
REQ-032 Hold blank_all=1 during a load of 16'h8888 -> hex stays all 1s; one cycle after blank_all drops, all digits show 0000000.
REQ-033 Assert rst_n=0 on the same edge as load with value=16'h5555 -> hex=all 1s, no load_ack, and state BLANK is held until a new load.
